// File: rtl/sort_result_streamer.sv
// Captures the merge sorter's packed result on done_in and streams it one word per valid/ready beat.
// Optional build macro SORT_RESULT_STREAMER_ORDER_CHECK_EN adds an ascending-order check on order_err.
module sort_result_streamer #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done_in,
  input  logic [N*W-1:0]       data_in,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun,
  output logic                 order_err
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx_n;
  logic [W-1:0]  data_n;
  logic          valid_n, last_n, fd_n, ovr_n;
  logic          capture, hs;
  logic [W-1:0]  mem [N];

  assign in_ready = (state == IDLE);

  // Frame buffer: loaded only on an accepted capture, never reset.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int k = 0; k < int'(N); k++) mem[k] <= data_in[k*W +: W];
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = out_index;
    data_n  = out_data;
    valid_n = out_valid;
    last_n  = out_last;
    fd_n    = 1'b0;
    ovr_n   = overrun | (done_in & (state != IDLE));
    capture = 1'b0;
    hs      = out_valid & out_ready;
    unique case (state)
      IDLE: begin
        if (done_in) begin
          capture = 1'b1;
          state_n = STREAM;
          idx_n   = '0;
          valid_n = 1'b1;
          last_n  = 1'b0;
          data_n  = data_in[W-1:0];
        end
      end
      STREAM: begin
        if (hs) begin
          if (out_last) begin
            state_n = IDLE;
            idx_n   = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
            fd_n    = 1'b1;
          end else begin
            // Preload the next word so out_data stays a plain register.
            idx_n  = out_index + IW'(1);
            last_n = (idx_n == LAST_IDX);
            data_n = mem[idx_n];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_index  <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      out_index  <= idx_n;
      out_data   <= data_n;
      out_valid  <= valid_n;
      out_last   <= last_n;
      frame_done <= fd_n;
      busy       <= (state_n == STREAM);
      overrun    <= ovr_n;
    end
  end

`ifdef SORT_RESULT_STREAMER_ORDER_CHECK_EN
  logic [W-1:0] prev, prev_n;
  logic         err, err_n, oerr_n;

  // Compare each handshaked beat against the previous one; publish the result with frame_done.
  always_comb begin
    prev_n = prev;
    err_n  = err;
    oerr_n = order_err;
    if (capture) begin
      err_n  = 1'b0;
      oerr_n = 1'b0;
    end else if (hs) begin
      prev_n = out_data;
      if ((out_index != '0) && (out_data < prev)) err_n = 1'b1;
      if (out_last) oerr_n = err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      err       <= 1'b0;
      order_err <= 1'b0;
    end else begin
      prev      <= prev_n;
      err       <= err_n;
      order_err <= oerr_n;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// Self-checking bench for sort_result_streamer: vector table of frame scenarios plus randomized frames.
module tb_sort_result_streamer;
  localparam int unsigned N  = 32;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = $clog2(N);

  typedef struct {
    int pat;        // word pattern selector
    int p;          // out_ready period (0 = random)
    int ovr_at;     // beat at which a stray done_in is injected (-1 none)
    int rst_at;     // beat at which rst is asserted (-1 none)
    bit b2b;        // next frame's done_in lands on the frame_done cycle
    int exp_cycles; // first-beat cycle to frame_done cycle (-1 unchecked)
    bit exp_ovr;    // overrun expected after the frame
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           done_in = 1'b0;
  logic [N*W-1:0] data_in = '0;
  logic           in_ready, out_valid, out_last, frame_done, busy, overrun, order_err;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_index;
  logic           out_ready = 1'b0;

  logic [W-1:0]   words [N];
  int             checks = 0;
  int             passed = 0;
  bit             exp_ovr = 1'b0;

  sort_result_streamer #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .data_in(data_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_ready(out_ready),
    .frame_done(frame_done), .busy(busy), .overrun(overrun), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int pat);
    logic [W-1:0] acc = '0;
    for (int k = 0; k < int'(N); k++) begin
      case (pat)
        0: words[k] = W'(10 * k);
        1: words[k] = (k == 7) ? W'(5) : W'(10 * k);
        2: begin acc = acc + W'($urandom_range(0, 3)); words[k] = acc; end
        3: words[k] = W'($urandom);
        default: words[k] = 32'h5A5A_0001;
      endcase
    end
  endtask

  function automatic logic [N*W-1:0] pack();
    logic [N*W-1:0] v;
    for (int k = 0; k < int'(N); k++) v[k*W +: W] = words[k];
    return v;
  endfunction

  // Expected order_err for a completed frame: any strictly descending neighbour pair.
  function automatic bit exp_order();
`ifdef SORT_RESULT_STREAMER_ORDER_CHECK_EN
    for (int k = 1; k < int'(N); k++) if (words[k] < words[k-1]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic send_frame();
    data_in = pack();
    done_in = 1'b1;
    chk("in_ready_before_capture", 64'(in_ready), 64'd1);
    tick();
    done_in = 1'b0;
    chk("first_beat_latency", 64'(out_valid), 64'd1);
    chk("order_err_cleared", 64'(order_err), 64'd0);
    chk("frame_done_low", 64'(frame_done), 64'd0);
  endtask

  task automatic stream(input int p, input int ovr_at, input int rst_at, input int exp_cycles);
    int beats = 0;
    bit hs;
    bit injected = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (out_valid) begin
        chk("out_index", 64'(out_index), 64'(beats));
        chk("out_data", 64'(out_data), 64'(words[beats]));
        chk("out_last", 64'(out_last), 64'(beats == int'(N) - 1));
        chk("busy", 64'(busy), 64'd1);
      end else begin
        chk("out_valid_held", 64'(out_valid), 64'd1);
      end
      out_ready = (p == 0) ? 1'($urandom_range(0, 1)) : 1'(c % p == 0);
      done_in = 1'b0;
      if (beats == ovr_at && out_ready && !injected) begin
        injected = 1'b1;
        done_in  = 1'b1;
        data_in  = ~pack();
        exp_ovr  = 1'b1;
      end
      if (beats == rst_at) rst = 1'b1;
      hs = out_valid && out_ready;
      tick();
      done_in = 1'b0;
      if (rst) begin
        rst = 1'b0;
        exp_ovr = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        tick();
        chk("rst_no_frame_done", 64'(frame_done), 64'd0);
        return;
      end
      if (injected) chk("overrun_sticky", 64'(overrun), 64'(exp_ovr));
      if (hs) beats++;
      if (beats == int'(N)) begin
        chk("frame_done", 64'(frame_done), 64'd1);
        chk("end_valid", 64'(out_valid), 64'd0);
        chk("end_in_ready", 64'(in_ready), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("order_err", 64'(order_err), 64'(exp_order()));
        chk("overrun_model", 64'(overrun), 64'(exp_ovr));
        if (exp_cycles >= 0) chk("frame_cycles", 64'(c + 1), 64'(exp_cycles));
        return;
      end
      chk("frame_done_early", 64'(frame_done), 64'd0);
    end
    chk("stream_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    vec_t vecs [9];
    int p;
    bit b2b;
    vecs[0] = '{0, 1, -1, -1, 1'b0, 32, 1'b0};
    vecs[1] = '{0, 3, -1, -1, 1'b0, 94, 1'b0};
    vecs[2] = '{0, 1,  5, -1, 1'b0, 32, 1'b1};
    vecs[3] = '{2, 2, -1, -1, 1'b0, 63, 1'b1};
    vecs[4] = '{0, 1, -1, 10, 1'b0, -1, 1'b0};
    vecs[5] = '{1, 1, -1, -1, 1'b1, 32, 1'b0};
    vecs[6] = '{2, 1, -1, -1, 1'b0, 32, 1'b0};
    vecs[7] = '{4, 2, 31, -1, 1'b0, 63, 1'b1};
    vecs[8] = '{3, 0, -1, -1, 1'b0, -1, 1'b1};

    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_out_index", 64'(out_index), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_order_err", 64'(order_err), 64'd0);

    // done_in together with rst must not start a frame.
    fill(0);
    data_in = pack();
    rst = 1'b1;
    done_in = 1'b1;
    tick();
    rst = 1'b0;
    done_in = 1'b0;
    chk("rst_wins_valid", 64'(out_valid), 64'd0);
    chk("rst_wins_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rst_wins_still_idle", 64'(out_valid), 64'd0);

    for (int i = 0; i < 9; i++) begin
      fill(vecs[i].pat);
      send_frame();
      stream(vecs[i].p, vecs[i].ovr_at, vecs[i].rst_at, vecs[i].exp_cycles);
      chk("overrun_expected", 64'(overrun), 64'(vecs[i].exp_ovr));
      if (!vecs[i].b2b) begin
        tick();
        chk("idle_frame_done_low", 64'(frame_done), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_valid", 64'(out_valid), 64'd0);
      end
    end

    for (int i = 0; i < 6; i++) begin
      p   = $urandom_range(0, 3);
      b2b = 1'($urandom_range(0, 1));
      fill($urandom_range(2, 3));
      send_frame();
      stream(p, -1, -1, (p == 0) ? -1 : p * (int'(N) - 1) + 1);
      if (!b2b) tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sort_result_streamer.md
Name: sort_result_streamer

Overview:
- Downstream stage of the merge sorter.
- Captures the sorter's packed result bus on its done pulse, then streams the words out one per beat over a valid/ready handshake, with last-beat and frame-complete signalling.
- Decouples the sorter's wide parallel output from the narrow consumer (output FIFO or memory writer).

Parameters:
N, 32, number of words per frame (power of two, >= 2)
W, 32, word width in bits (N*W = 1024 matches the sorter output bus)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
done_in  input  1  one-cycle pulse from the sorter; data_in valid in the same cycle
data_in  input  N*W  packed sorted words; word k at data_in[k*W +: W]
in_ready  output  1  high when a done_in pulse will be accepted (state IDLE)
out_valid  output  1  beat valid
out_data  output  W  current word
out_index  output  $clog2(N)  index of the current word (0..N-1)
out_last  output  1  high with out_valid on word N-1
out_ready  input  1  consumer accepts the beat
frame_done  output  1  one-cycle pulse after the last beat handshake
busy  output  1  high while in STREAM
overrun  output  1  sticky: done_in arrived while in_ready was low
order_err  output  1  order-check result (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, index=0, out_valid=0, out_last=0, frame_done=0, busy=0, overrun=0, order_err=0, in_ready=1. The capture buffer is not reset.
- in_ready = (state==IDLE). Combinational, registered state only.
- IDLE:
  - If done_in=1, capture all N words into the internal buffer on that edge, set index=0, go to STREAM.
  - out_valid goes high in the next cycle, giving 1-cycle latency from done_in to the first beat.
- STREAM:
  - out_valid=1, out_data=buf[index], out_index=index, out_last=(index==N-1), busy=1.
  - Handshake = out_valid && out_ready.
  - On a handshake with index<N-1: index increments and the next word is presented next cycle.
  - Without a handshake: out_data, out_index and out_last hold stable. AXI-style; valid is never withdrawn.
  - On a handshake with index==N-1: go to IDLE, index=0, out_valid=0 and frame_done=1 for exactly the next cycle.
- Throughput: with out_ready held high, N beats on N consecutive cycles, then one IDLE cycle before the next capture can occur. Frame period is N+1 cycles minimum.
- done_in while not in IDLE (including on the final-beat cycle): pulse ignored, buffer unchanged, overrun set to 1. Only rst clears overrun.
- done_in with rst high: rst wins, nothing captured.
- Reset mid-frame: the next cycle is IDLE with out_valid=0, and no frame_done is generated. The remaining beats are lost.
- out_ready low indefinitely: the block stalls in STREAM with no timeout.

Optional Feature:
Macro SORT_RESULT_STREAMER_ORDER_CHECK_EN.
- Defined:
  - Every handshaked beat with index>0 is compared, unsigned, against the previously handshaked word of the same frame.
  - If current < previous, the internal error flag sets.
  - order_err is driven with the frame's result in the same cycle frame_done is high, and holds until the next capture.
  - A capture clears the flag.
  - Equal words are not an error.
- Not defined: order_err tied to 0, and no comparator or previous-word register is built.

Test Plan:
- Basic frame: load words k=0..31 with value 10*k, pulse done_in, out_ready=1 -> out_valid high the cycle after done_in; 32 consecutive beats 0,10,...,310; out_last only on value 310 (index 31); frame_done one cycle later; in_ready=1 again.
- Backpressure: same frame, out_ready toggled 1,0,0,1,... -> no word skipped or duplicated; out_data and out_index stable while out_ready=0; total beats=32.
- Overrun: pulse done_in again at beat 5 with different data -> overrun=1 and stays 1; the streamed frame is unchanged (first data).
- Reset mid-frame: rst at beat 10 -> next cycle out_valid=0, busy=0, in_ready=1, no frame_done; a new done_in then streams from index 0.
- Back-to-back: done_in on the frame_done cycle -> accepted; second frame starts the following cycle with overrun=0.
- Order check (macro defined): word 7 = 5 with word 6 = 60 -> order_err=1 on the frame_done cycle; next frame fully ascending -> order_err=0. Macro undefined -> order_err always 0.
